load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised load/store unit between the core's execute stage and a handshaked data-memory port.
- Replaces the combinational memory-data masking path with a multi-cycle engine. The engine adds:
  - byte-lane strobes,
  - sign/zero extension,
  - misalignment and illegal-size detection,
  - bus error reporting,
  - a grant/response timeout.
- Handles one outstanding access at a time.

Parameters:
XLEN, 32, data width; 32 or 64 (64 enables LD/SD/LWU)
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 256, max cycles spent in REQ+WAIT before timeout error; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  core access request
req_ready  out  1  unit can accept request (high only in IDLE)
req_write  in  1  1=store, 0=load
req_funct  in  3  RISC-V funct3 (size/sign)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  XLEN  store data, LSB-aligned
req_rd  in  5  destination register tag, returned with response
resp_valid  out  1  one-cycle response pulse
resp_write  out  1  echo of req_write
resp_rd  out  5  echo of req_rd
resp_rdata  out  XLEN  formatted load data; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  bus write enable
mem_addr  out  ADDR_WIDTH  word-aligned address (low log2(XLEN/8) bits zero)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-shifted store data
mem_gnt  in  1  bus accepts request this cycle
mem_rvalid  in  1  bus response; earliest one cycle after mem_gnt
mem_rdata  in  XLEN  bus read data
mem_err  in  1  bus error, qualified by mem_rvalid
busy  out  1  high whenever state != IDLE

Behaviour:

Reset:
- All outputs 0 except req_ready=1.
- State IDLE, timeout counter 0, orphan flag 0.
- Reset mid-access aborts it. No response is produced.

FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - If misaligned or illegal, go to RESP with err=01 and never touch the bus.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 with stable mem_we/addr/be/wdata, except while the orphan flag is set: then mem_req=0 and the unit waits.
  - On mem_gnt, go to WAIT.
- WAIT:
  - On mem_rvalid, capture data and go to RESP.
  - err=10 if mem_err (rdata forced to 0).
- RESP:
  - resp_valid=1 for exactly one cycle; the core always accepts.
  - Next state IDLE.

Size legality:
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; with XLEN=64 also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW; with XLEN=64 also 011 SD.
- Anything else is illegal, err=01.

Alignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0.

Lane formatting:
- off = addr[log2(XLEN/8)-1:0].
- mem_be = size mask (1, 3, F, FF) << off.
- mem_wdata = req_wdata << 8*off; bytes outside mem_be are don't-care but driven deterministically.
- Load data = (mem_rdata >> 8*off), truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU).

Timeout:
- Counter clears on IDLE→REQ and increments each cycle in REQ or WAIT.
- When it reaches TIMEOUT_CYCLES, go to RESP with err=11 and drop mem_req.
- If the timeout occurs in WAIT, set the orphan flag.
- The next mem_rvalid clears the orphan flag and is discarded.

Latency:
- Minimum 3 cycles from the accept edge to resp_valid: gnt in the first REQ cycle, rvalid in the next cycle.
- Error at decode: resp_valid on the cycle after accept.
- No request is accepted while busy. Back-to-back accesses have at least one IDLE cycle between them.

Simultaneous events:
- Timeout in the same cycle as mem_gnt: the grant wins and the FSM goes to WAIT.
- Timeout in the same cycle as mem_rvalid: the response wins.

Test Plan:
- XLEN=32. SW addr=0x100, wdata=0xDEADBEEF, gnt immediate, rvalid next cycle.
  -> mem_addr=0x100, mem_be=4'b1111, mem_we=1, resp_valid 3 cycles after accept, resp_err=00, resp_rdata=0.
- LB addr=0x103 with mem_rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80. Same with LBU -> 0x00000080. mem_addr=0x100, mem_be=4'b1000.
- SH addr=0x102, wdata=0x0000ABCD -> mem_be=4'b1100, mem_wdata[31:16]=0xABCD. LHU of the same location returning 0xABCD0000 -> resp_rdata=0x0000ABCD.
- LW addr=0x102 -> resp_err=01 on the cycle after accept, mem_req never asserted. funct3=011 at XLEN=32 -> err=01.
- TIMEOUT_CYCLES=8, gnt withheld -> resp_err=11 after 8 REQ cycles, then mem_req=0.
  - Repeat with gnt given and rvalid withheld: orphan flag is set. The next request holds mem_req low until a late rvalid arrives; that rvalid is discarded.
- reset asserted while in WAIT -> next cycle: busy=0, req_ready=1, resp_valid=0, mem_req=0. A subsequent LW addr=0x0 completes normally with err=00.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a core access, drives a handshaked data-memory port with
// lane-shifted data and byte enables, then returns formatted load data or an error code.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [4:0]            resp_rd,
  output logic [XLEN-1:0]       resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_err,
  output logic                  busy
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int CNTW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0] TO_LIMIT = CNTW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                r_state;
  logic                  r_reqReady;
  logic                  r_busy;
  logic                  r_respValid;
  logic                  r_respWrite;
  logic [4:0]            r_respRd;
  logic [XLEN-1:0]       r_respRdata;
  logic [1:0]            r_respErr;
  logic                  r_memReq;
  logic                  r_memWe;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [NBYTES-1:0]     r_memBe;
  logic [XLEN-1:0]       r_memWdata;
  logic [2:0]            r_funct;
  logic [OFFW-1:0]       r_off;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_orphan;

  logic                  w_legal;
  logic                  w_aligned;
  logic                  w_decErr;
  logic [OFFW-1:0]       w_off;
  logic [NBYTES-1:0]     w_sizeMask;
  logic [NBYTES-1:0]     w_be;
  logic [XLEN-1:0]       w_wdata;
  logic [XLEN-1:0]       w_shifted;
  logic [XLEN-1:0]       w_loadData;
  logic [CNTW-1:0]       w_cntInc;
  logic                  w_timeout;
  logic                  w_orphanNext;

  assign w_off = req_addr[OFFW-1:0];

  // Size legality and natural alignment of the incoming request
  always_comb begin
    w_legal = 1'b0;
    case (req_funct)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b011:                 w_legal = (XLEN == 64);
      3'b100, 3'b101:         w_legal = !req_write;
      3'b110:                 w_legal = !req_write && (XLEN == 64);
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned  = 1'b1;
    w_sizeMask = '1;
    case (req_funct[1:0])
      2'd0: begin w_aligned = 1'b1;                w_sizeMask = NBYTES'(1);  end
      2'd1: begin w_aligned = !req_addr[0];        w_sizeMask = NBYTES'(3);  end
      2'd2: begin w_aligned = req_addr[1:0] == '0; w_sizeMask = NBYTES'(15); end
      default: begin w_aligned = req_addr[2:0] == '0; w_sizeMask = '1; end
    endcase
  end

  assign w_decErr = !w_legal || !w_aligned;
  assign w_be     = w_sizeMask << w_off;
  assign w_wdata  = req_wdata << {w_off, 3'b000};

  // Bring the addressed lane down to bit 0, then truncate and extend by funct3
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_loadData = w_shifted;
    case (r_funct)
      3'b000:  w_loadData = XLEN'($signed(w_shifted[7:0]));
      3'b001:  w_loadData = XLEN'($signed(w_shifted[15:0]));
      3'b010:  w_loadData = XLEN'($signed(w_shifted[31:0]));
      3'b100:  w_loadData = XLEN'(w_shifted[7:0]);
      3'b101:  w_loadData = XLEN'(w_shifted[15:0]);
      3'b110:  w_loadData = XLEN'(w_shifted[31:0]);
      default: w_loadData = w_shifted;
    endcase
  end

  // Counter saturates at the limit so a grant that beat the timeout still times out in WAIT
  assign w_cntInc     = (r_cnt == TO_LIMIT) ? r_cnt : r_cnt + CNTW'(1);
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (w_cntInc == TO_LIMIT);
  assign w_orphanNext = r_orphan && !mem_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_reqReady  <= 1'b1;
      r_busy      <= 1'b0;
      r_respValid <= 1'b0;
      r_respWrite <= 1'b0;
      r_respRd    <= '0;
      r_respRdata <= '0;
      r_respErr   <= 2'b00;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memBe     <= '0;
      r_memWdata  <= '0;
      r_funct     <= '0;
      r_off       <= '0;
      r_cnt       <= '0;
      r_orphan    <= 1'b0;
    end else begin
      r_respValid <= 1'b0;
      if (mem_rvalid) r_orphan <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_respWrite <= req_write;
            r_respRd    <= req_rd;
            r_funct     <= req_funct;
            r_off       <= w_off;
            r_reqReady  <= 1'b0;
            r_busy      <= 1'b1;
            if (w_decErr) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_respErr   <= 2'b01;
              r_respRdata <= '0;
            end else begin
              r_state    <= REQ;
              r_cnt      <= '0;
              r_memReq   <= !w_orphanNext;
              r_memWe    <= req_write;
              r_memAddr  <= {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
              r_memBe    <= w_be;
              r_memWdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (r_memReq && mem_gnt) begin
            r_state  <= WAIT;
            r_memReq <= 1'b0;
            r_cnt    <= w_cntInc;
          end else if (w_timeout) begin
            r_state     <= RESP;
            r_memReq    <= 1'b0;
            r_respValid <= 1'b1;
            r_respErr   <= 2'b11;
            r_respRdata <= '0;
          end else begin
            r_cnt    <= w_cntInc;
            r_memReq <= !w_orphanNext;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_respErr   <= mem_err ? 2'b10 : 2'b00;
            r_respRdata <= (mem_err || r_respWrite) ? '0 : w_loadData;
          end else if (w_timeout) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_respErr   <= 2'b11;
            r_respRdata <= '0;
            r_orphan    <= 1'b1;
          end else begin
            r_cnt <= w_cntInc;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_reqReady <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_reqReady;
  assign busy       = r_busy;
  assign resp_valid = r_respValid;
  assign resp_write = r_respWrite;
  assign resp_rd    = r_respRd;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;
  assign mem_req    = r_memReq;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_be     = r_memBe;
  assign mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, TIMEOUT_CYCLES=8): directed cases
// plus random accesses compared against a cycle-count/arithmetic reference model.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            resp_valid;
  logic            resp_write;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_rdata;
  logic [1:0]      resp_err;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;
  logic            busy;

  int checks = 0;
  int errors = 0;
  bit orphanPending = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  load_store_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_write(resp_write), .resp_rd(resp_rd),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit modelLegal(input bit write, input logic [2:0] f);
    if (write) return f inside {3'd0, 3'd1, 3'd2};
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int sizeBytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] data);
    int n;
    int off;
    logic [63:0] v;
    logic [63:0] m;
    n   = sizeBytes(f);
    off = int'(addr[1:0]);
    v   = {32'd0, data} >> (8 * off);
    m   = (64'd1 << (8 * n)) - 64'd1;
    v   = v & m;
    if (!f[2] && v[8*n-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // One access: the bench plays the memory (grant after gd REQ cycles, response after rd WAIT
  // cycles, stray orphan response after od cycles) and compares against the model.
  task automatic applyStimulus(input string tag, input bit write, input logic [2:0] f,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input bit berr,
                               input int gd, input int rd, input int od);
    int n, off, edges, pre, g, r, lastCyc, expLat, reqSeen, wcnt, phase, oc;
    bit decErr, expBus, sawReq, orphanReq, expOrphan;
    logic [1:0]  expErr;
    logic [31:0] expData, expWdata, beMask;
    logic [3:0]  expBe;
    logic [4:0]  rdTag;
    logic        obsWe;
    logic [31:0] obsAddr, obsWdata;
    logic [3:0]  obsBe;

    n      = sizeBytes(f);
    off    = int'(addr[1:0]);
    rdTag  = 5'($urandom);
    decErr = !modelLegal(write, f) || ((int'(addr[2:0]) % n) != 0);
    expOrphan = orphanPending;
    expBus = !decErr;
    expErr = 2'b01;
    expLat = 1;
    if (!decErr) begin
      pre = orphanPending ? od + 1 : 0;
      g   = pre + gd + 1;
      if (g > TO) begin
        expErr = 2'b11;
        expLat = TO + 1;
      end else begin
        expOrphan = 1'b0;
        r = g + rd + 1;
        lastCyc = (g + 1 > TO) ? g + 1 : TO;
        if (r <= lastCyc) begin
          expErr = berr ? 2'b10 : 2'b00;
          expLat = r + 1;
        end else begin
          expErr = 2'b11;
          expLat = lastCyc + 1;
          expOrphan = 1'b1;
        end
      end
    end
    expData  = (expErr == 2'b00 && !write) ? modelLoad(f, addr, rdata) : 32'd0;
    expBe    = 4'(((1 << n) - 1) << off);
    expWdata = wdata << (8 * off);
    for (int b = 0; b < 4; b++) beMask[8*b +: 8] = {8{expBe[b]}};

    @(negedge clk);
    checkOutput({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = write;
    req_funct = f;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rdTag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_funct = 3'($urandom);

    edges = 0; phase = 0; reqSeen = 0; wcnt = 0; oc = 0; sawReq = 0; orphanReq = 0;
    obsWe = 1'bx; obsAddr = 'x; obsWdata = 'x; obsBe = 'x;
    while (!resp_valid && edges < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
      if (phase == 0) begin
        if (orphanPending) begin
          if (mem_req) orphanReq = 1'b1;
          if (oc == od) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0BAD0;
            orphanPending = 1'b0;
          end
          oc++;
        end else if (mem_req) begin
          if (!sawReq) begin
            sawReq = 1'b1; obsWe = mem_we; obsAddr = mem_addr; obsBe = mem_be; obsWdata = mem_wdata;
          end
          if (reqSeen >= gd) begin
            mem_gnt = 1'b1;
            phase = 1;
          end
          reqSeen++;
        end
      end else if (phase == 1) begin
        if (wcnt >= rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
          mem_err    = berr;
          phase = 2;
        end
        wcnt++;
      end
      @(posedge clk); #1;
      edges++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;

    checkOutput({tag, ".respSeen"}, resp_valid, 1);
    checkOutput({tag, ".latency"}, edges + 1, expLat);
    checkOutput({tag, ".err"}, resp_err, expErr);
    checkOutput({tag, ".rdata"}, resp_rdata, expData);
    checkOutput({tag, ".write"}, resp_write, write);
    checkOutput({tag, ".rd"}, resp_rd, rdTag);
    checkOutput({tag, ".busyInResp"}, busy, 1);
    checkOutput({tag, ".memReqInResp"}, mem_req, 0);
    checkOutput({tag, ".busTouched"}, sawReq, expBus);
    checkOutput({tag, ".orphanHold"}, orphanReq, 0);
    if (sawReq && expBus) begin
      checkOutput({tag, ".memWe"}, obsWe, write);
      checkOutput({tag, ".memAddr"}, obsAddr, addr & 32'hFFFF_FFFC);
      checkOutput({tag, ".memBe"}, obsBe, expBe);
      checkOutput({tag, ".memWdata"}, obsWdata & beMask, expWdata & beMask);
    end
    @(posedge clk); #1;
    checkOutput({tag, ".pulse"}, resp_valid, 0);
    checkOutput({tag, ".readyAfter"}, req_ready, 1);
    checkOutput({tag, ".idleBusy"}, busy, 0);
    orphanPending = expOrphan;
  endtask

  // Directed sequence followed by random traffic
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct = 3'd0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.ready", req_ready, 1);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.respValid", resp_valid, 0);
    checkOutput("reset.memReq", mem_req, 0);
    checkOutput("reset.respErr", resp_err, 0);
    checkOutput("reset.memBe", mem_be, 0);
    checkOutput("reset.memWe", mem_we, 0);
    reset = 1'b0;

    applyStimulus("sw",      1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 0, 0, 0);
    applyStimulus("lb",      1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1'b0, 0, 0, 0);
    applyStimulus("lbu",     1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1'b0, 0, 0, 0);
    applyStimulus("sh",      1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        1'b0, 1, 0, 0);
    applyStimulus("lhu",     1'b0, 3'b101, 32'h102, 32'h0,        32'hABCD0000, 1'b0, 0, 2, 0);
    applyStimulus("lh",      1'b0, 3'b001, 32'h102, 32'h0,        32'h8001FFFF, 1'b0, 0, 0, 0);
    applyStimulus("lwMisal", 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b0, 0, 0, 0);
    applyStimulus("ld32",    1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b0, 0, 0, 0);
    applyStimulus("lwu32",   1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        1'b0, 0, 0, 0);
    applyStimulus("sIll",    1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b0, 0, 0, 0);
    applyStimulus("busErr",  1'b0, 3'b010, 32'h104, 32'h0,        32'h12345678, 1'b1, 0, 1, 0);
    applyStimulus("toReq",   1'b0, 3'b010, 32'h108, 32'h0,        32'h0,        1'b0, 20, 0, 0);
    applyStimulus("gntAtTo", 1'b0, 3'b010, 32'h10C, 32'h0,        32'h55AA55AA, 1'b0, 7, 0, 0);
    applyStimulus("rvAtTo",  1'b0, 3'b000, 32'h10D, 32'h0,        32'h00007F00, 1'b0, 6, 0, 0);
    applyStimulus("toWait",  1'b0, 3'b010, 32'h110, 32'h0,        32'h0,        1'b0, 0, 20, 0);
    applyStimulus("orphan1", 1'b0, 3'b010, 32'h114, 32'h0,        32'hCAFEF00D, 1'b0, 0, 0, 3);
    applyStimulus("toWait2", 1'b0, 3'b010, 32'h118, 32'h0,        32'h0,        1'b0, 7, 1, 0);
    applyStimulus("orphan2", 1'b1, 3'b000, 32'h11B, 32'h000000A5, 32'h0,        1'b0, 0, 0, 0);

    // Reset while waiting for the bus response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct = 3'b010; req_addr = 32'h40; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rstWait.memReq", mem_req, 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("rstWait.busyInWait", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rstWait.busy", busy, 0);
    checkOutput("rstWait.ready", req_ready, 1);
    checkOutput("rstWait.respValid", resp_valid, 0);
    checkOutput("rstWait.memReq", mem_req, 0);
    @(posedge clk); #1;
    checkOutput("rstWait.noResp", resp_valid, 0);
    applyStimulus("lwAfterRst", 1'b0, 3'b010, 32'h0, 32'h0, 32'h13572468, 1'b0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'h200 + 32'($urandom_range(0, 63)), $urandom, $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
